// File: rtl/wb_pkg.sv
// Shared types, constants and the round-robin pick helper for the
// writeback scheduler.
package wb_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 2 ** REG_AW;
    localparam int MAX_REQ  = 8;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First valid index at or after ptr, wrapping modulo n.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [2:0]         ptr,
        input int                 n
    );
        rr_pick_t r;
        int       i;
        r = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            i = {29'd0, ptr} + k;
            if (i >= n) i = i - n;
            if (k < n && !r.found && valid[i[2:0]]) begin
                r.found = 1'b1;
                r.idx   = i[2:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin grant over NUM_REQ writeback requesters; the pointer moves
// past the winner on every accepted transfer.
module wb_rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [2:0]         grant_idx
);
    import wb_pkg::*;

    logic [2:0]         rr_ptr;
    logic [MAX_REQ-1:0] valid_pad;
    rr_pick_t           pick;

    always_comb begin
        valid_pad              = '0;
        valid_pad[NUM_REQ-1:0] = req_valid;
        pick                   = rr_pick(valid_pad, rr_ptr, NUM_REQ);
    end

    assign grant_valid = pick.found;
    assign grant_idx   = pick.idx;

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++)
            grant[i] = pick.found && (pick.idx == 3'(i));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rr_ptr <= '0;
        else if (pick.found)
            rr_ptr <= (int'(pick.idx) + 1 == NUM_REQ) ? 3'd0
                                                      : pick.idx + 3'd1;
    end

endmodule

// File: rtl/wb_scheduler.sv
// Register-file write port sharing with a registered output stage and a
// pending-write scoreboard for RAW/WAW hazard detection at issue.
module wb_scheduler #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = wb_pkg::XLEN,
    parameter int REG_AW  = wb_pkg::REG_AW
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*REG_AW-1:0] req_rd,
    input  logic [NUM_REQ*XLEN-1:0]   req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      issue_valid,
    input  logic [REG_AW-1:0]         issue_rd,
    output logic                      issue_ready,
    input  logic [REG_AW-1:0]         rs1_sel,
    input  logic [REG_AW-1:0]         rs2_sel,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    input  logic                      flush,
    output logic                      reg_write,
    output logic [REG_AW-1:0]         rd_sel,
    output logic [XLEN-1:0]           wb_data
);
    import wb_pkg::*;

    localparam int NREG = 2 ** REG_AW;

    logic              grant_valid;
    logic [2:0]        grant_idx;
    logic [REG_AW-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;
    logic [NREG-1:0]   sb;
    logic [NREG-1:0]   sb_next;
    logic              issue_fire;

    wb_rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .grant      (req_ready),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx)
    );

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == 3'(i)) begin
                sel_rd   = req_rd[i*REG_AW +: REG_AW];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_write <= 1'b0;
            rd_sel    <= '0;
            wb_data   <= '0;
        end else if (grant_valid) begin
            reg_write <= (sel_rd != '0);
            rd_sel    <= sel_rd;
            wb_data   <= sel_data;
        end else begin
            reg_write <= 1'b0;
        end
    end

    assign issue_ready = ~sb[issue_rd];
    assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);
    assign rs1_busy    = sb[rs1_sel];
    assign rs2_busy    = sb[rs2_sel];

    // Clear lands with the register-file write; a same-cycle set wins.
    always_comb begin
        sb_next = sb;
        if (reg_write)
            sb_next[rd_sel] = 1'b0;
        if (issue_fire)
            sb_next[issue_rd] = 1'b1;
        if (flush)
            sb_next = '0;
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            sb <= '0;
        else
            sb <= sb_next;
    end

endmodule

// File: tb/tb_wb_scheduler.sv
// Self-checking bench for wb_scheduler: directed scenarios plus a random
// run against a behavioural model of arbitration and the scoreboard.
module tb_wb_scheduler;

    localparam int N  = 3;
    localparam int XL = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N*AW-1:0] req_rd = '0;
    logic [N*XL-1:0] req_data = '0;
    logic [N-1:0]  req_ready;
    logic          issue_valid = 1'b0;
    logic [AW-1:0] issue_rd = '0;
    logic          issue_ready;
    logic [AW-1:0] rs1_sel = '0;
    logic [AW-1:0] rs2_sel = '0;
    logic          rs1_busy;
    logic          rs2_busy;
    logic          flush = 1'b0;
    logic          reg_write;
    logic [AW-1:0] rd_sel;
    logic [XL-1:0] wb_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int        m_ptr;
    bit        m_rw;
    bit [4:0]  m_rd;
    bit [31:0] m_data;
    bit [31:0] m_sb;

    wb_scheduler #(.NUM_REQ(N), .XLEN(XL), .REG_AW(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_rd     (req_rd),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .issue_ready(issue_ready),
        .rs1_sel    (rs1_sel),
        .rs2_sel    (rs2_sel),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .flush      (flush),
        .reg_write  (reg_write),
        .rd_sel     (rd_sel),
        .wb_data    (wb_data)
    );

    always #5 clk = ~clk;

    function automatic int exp_grant();
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input bit v,
                           input bit [4:0] rd, input bit [31:0] d);
        req_valid[i]          = v;
        req_rd[i*AW +: AW]    = rd;
        req_data[i*XL +: XL]  = d;
    endtask

    // Advance model by one edge using current inputs, then step the DUT.
    task automatic tick();
        int        g;
        bit [31:0] nsb;
        g   = exp_grant();
        nsb = m_sb;
        if (m_rw) nsb[m_rd] = 1'b0;
        if (issue_valid && !m_sb[issue_rd] && issue_rd != 0)
            nsb[issue_rd] = 1'b1;
        if (flush) nsb = '0;
        nsb[0] = 1'b0;
        m_sb = nsb;
        if (g >= 0) begin
            m_rd   = req_rd[g*AW +: AW];
            m_data = req_data[g*XL +: XL];
            m_rw   = (m_rd != 0);
            m_ptr  = (g + 1) % N;
        end else begin
            m_rw = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_rw   = 0;
        m_rd   = '0;
        m_data = '0;
        m_sb   = '0;
    endtask

    task automatic clear_inputs();
        req_valid   = '0;
        req_rd      = '0;
        req_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        flush       = 1'b0;
        rs1_sel     = '0;
        rs2_sel     = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        tick();
        issue_valid = 1'b0;
        set_req(0, 1'b1, 5'd6, 32'hCAFE0006);
        tick();
        req_valid = '0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (reg_write !== 1'b0 || rd_sel !== 5'd0 || wb_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_out: got rw=%0b rd=%0d data=%h want 0/0/0",
                     reg_write, rd_sel, wb_data);
        end
        clear_inputs();
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        issue_rd = 5'd3;
        #1;
        n_checks++;
        if (issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_issue_ready: got %b want 1", issue_ready);
        end
        for (int r = 1; r < 32; r++) begin
            rs1_sel = 5'(r);
            #1;
            n_checks++;
            if (rs1_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_busy r%0d: got %b want 0", r, rs1_busy);
            end
        end
        req_valid = 3'b111;
        #1;
        n_checks++;
        if (req_ready !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_ptr: got %b want 001", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_single_write();
        do_reset();
        set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        n_checks++;
        if (req_ready !== 3'b001) begin
            n_fail++;
            $display("FAIL single_ready: got %b want 001", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        n_checks++;
        if (reg_write !== 1'b1 || rd_sel !== 5'd5 || wb_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL single_c1: got rw=%0b rd=%0d data=%h want 1/5/deadbeef",
                     reg_write, rd_sel, wb_data);
        end
        tick();
        n_checks++;
        if (reg_write !== 1'b0 || rd_sel !== 5'd5 || wb_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL single_c2: got rw=%0b rd=%0d data=%h want 0/5/deadbeef",
                     reg_write, rd_sel, wb_data);
        end
    endtask

    task automatic test_fairness();
        bit [2:0] want;
        do_reset();
        for (int i = 0; i < N; i++)
            set_req(i, 1'b1, 5'(10 + i), 32'h1000 + i);
        for (int k = 0; k < 6; k++) begin
            want = 3'(1 << (k % N));
            #1;
            n_checks++;
            if (req_ready !== want) begin
                n_fail++;
                $display("FAIL fair_grant k%0d: got %b want %b", k, req_ready, want);
            end
            tick();
            n_checks++;
            if (reg_write !== 1'b1 || rd_sel !== 5'(10 + k % N)) begin
                n_fail++;
                $display("FAIL fair_out k%0d: got rw=%0b rd=%0d want 1/%0d",
                         k, reg_write, rd_sel, 10 + k % N);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_hazard();
        do_reset();
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        #1;
        n_checks++;
        if (issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hz_ready0: got %b want 1", issue_ready);
        end
        tick();
        issue_valid = 1'b0;
        rs1_sel     = 5'd7;
        #1;
        n_checks++;
        if (rs1_busy !== 1'b1 || issue_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hz_busy: got busy=%b ready=%b want 1/0", rs1_busy, issue_ready);
        end
        set_req(1, 1'b1, 5'd7, 32'h77);
        tick();
        req_valid = '0;
        #1;
        n_checks++;
        if (reg_write !== 1'b1 || rs1_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL hz_inflight: got rw=%b busy=%b want 1/1", reg_write, rs1_busy);
        end
        tick();
        n_checks++;
        if (rs1_busy !== 1'b0 || issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hz_clear: got busy=%b ready=%b want 0/1", rs1_busy, issue_ready);
        end
    endtask

    task automatic test_rd0();
        do_reset();
        set_req(0, 1'b1, 5'd0, 32'h1);
        #1;
        n_checks++;
        if (req_ready !== 3'b001) begin
            n_fail++;
            $display("FAIL rd0_ready: got %b want 001", req_ready);
        end
        tick();
        req_valid   = '0;
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        #1;
        n_checks++;
        if (reg_write !== 1'b0 || issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rd0_write: got rw=%b ready=%b want 0/1", reg_write, issue_ready);
        end
        tick();
        issue_valid = 1'b0;
        rs1_sel     = 5'd0;
        rs2_sel     = 5'd0;
        req_valid   = 3'b111;
        #1;
        n_checks++;
        if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || req_ready !== 3'b010) begin
            n_fail++;
            $display("FAIL rd0_after: got b1=%b b2=%b grant=%b want 0/0/010",
                     rs1_busy, rs2_busy, req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_req(0, 1'b1, 5'd9, 32'h99);
        tick();
        req_valid   = '0;
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        #1;
        n_checks++;
        if (reg_write !== 1'b1 || issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sim_pre: got rw=%b ready=%b want 1/1", reg_write, issue_ready);
        end
        tick();
        issue_valid = 1'b0;
        rs1_sel     = 5'd9;
        #1;
        n_checks++;
        if (rs1_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL sim_setwins: got %b want 1", rs1_busy);
        end
        flush       = 1'b1;
        issue_valid = 1'b1;
        issue_rd    = 5'd4;
        set_req(2, 1'b1, 5'd12, 32'h1212);
        tick();
        flush       = 1'b0;
        issue_valid = 1'b0;
        req_valid   = '0;
        #1;
        n_checks++;
        if (reg_write !== 1'b1 || rd_sel !== 5'd12 || wb_data !== 32'h1212) begin
            n_fail++;
            $display("FAIL sim_flush_out: got rw=%b rd=%0d data=%h want 1/12/1212",
                     reg_write, rd_sel, wb_data);
        end
        for (int r = 0; r < 32; r++) begin
            rs2_sel = 5'(r);
            #1;
            n_checks++;
            if (rs2_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL sim_flush r%0d: got %b want 0", r, rs2_busy);
            end
        end
    endtask

    task automatic test_random();
        int g;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) != 0)
                    set_req(i, 1'b1, 5'($urandom_range(0, 31)), $urandom);
                else if (req_valid[i] && $urandom_range(0, 15) == 0)
                    req_valid[i] = 1'b0;
            end
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd    = 5'($urandom_range(0, 31));
            rs1_sel     = 5'($urandom_range(0, 31));
            rs2_sel     = 5'($urandom_range(0, 31));
            flush       = ($urandom_range(0, 19) == 0);
            #1;
            g = exp_grant();
            n_checks++;
            if (req_ready !== ((g < 0) ? 3'b000 : 3'(1 << g))) begin
                n_fail++;
                $display("FAIL rnd_grant c%0d: got %b want idx %0d", c, req_ready, g);
            end
            n_checks++;
            if (issue_ready !== !m_sb[issue_rd] || rs1_busy !== m_sb[rs1_sel]
                || rs2_busy !== m_sb[rs2_sel]) begin
                n_fail++;
                $display("FAIL rnd_sb c%0d: got ir=%b b1=%b b2=%b want %b/%b/%b", c,
                         issue_ready, rs1_busy, rs2_busy,
                         !m_sb[issue_rd], m_sb[rs1_sel], m_sb[rs2_sel]);
            end
            tick();
            if (g >= 0) req_valid[g] = 1'b0;
            n_checks++;
            if (reg_write !== m_rw || rd_sel !== m_rd || wb_data !== m_data) begin
                n_fail++;
                $display("FAIL rnd_out c%0d: got %b/%0d/%h want %b/%0d/%h", c,
                         reg_write, rd_sel, wb_data, m_rw, m_rd, m_data);
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fairness();
        test_hazard();
        test_rd0();
        test_simultaneous();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_scheduler.md
Name: wb_scheduler

Overview:
- Shares the register file's single write port among NUM_REQ writeback sources (ALU, LSU, MUL/DIV) using round-robin arbitration.
- Drives the register file's reg_write, rd_sel and wb_data from a registered output stage.
- Keeps a per-register pending-write scoreboard so issue logic can detect RAW and WAW hazards.
- Sits between the execute/memory units and the register file.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- XLEN, 32, data width.
- REG_AW, 5, register address width (2**REG_AW architectural registers).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  requester i has a writeback pending.
- req_rd  in  NUM_REQ*REG_AW  destination register, requester i at slice i.
- req_data  in  NUM_REQ*XLEN  writeback data, requester i at slice i.
- req_ready  out  NUM_REQ  one-hot grant; transfer when valid&ready.
- issue_valid  in  1  instruction issuing with a destination register.
- issue_rd  in  REG_AW  destination of the issuing instruction.
- issue_ready  out  1  issue may complete; low while issue_rd is pending.
- rs1_sel, rs2_sel  in  REG_AW each  source registers being read at issue.
- rs1_busy, rs2_busy  out  1 each  source register has a pending write.
- flush  in  1  synchronous scoreboard clear (pipeline flush).
- reg_write  out  1  register file write enable.
- rd_sel  out  REG_AW  register file write address.
- wb_data  out  XLEN  register file write data.

Behaviour:
- Reset (reset_n low, asynchronous): reg_write=0, rd_sel=0, wb_data=0, scoreboard all 0, rr_ptr=0. Reset mid-transfer drops any in-flight write.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ. The first valid index g gets req_ready[g]=1; all others get 0.
  - With no valid requester, req_ready is all zero.
  - req_ready never asserts for an invalid requester.
- Accept: on a clock edge with a grant, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Output stage (1-cycle latency):
  - On the edge of acceptance: rd_sel <= req_rd[g], wb_data <= req_data[g], reg_write <= (req_rd[g] != 0).
  - With no accept: reg_write <= 0, and rd_sel/wb_data hold.
  - The register file therefore writes on the edge after reg_write rises: 2 edges from accept to architectural state.
  - An rd=0 request is accepted and consumed but produces no write.
- Throughput: one writeback per cycle. The output stage never back-pressures.
- Scoreboard: sb[2**REG_AW] flops; sb[0] is hard-wired 0.
  - Set: issue_valid & issue_ready & issue_rd != 0 sets sb[issue_rd].
  - Clear: reg_write=1 clears sb[rd_sel] on the same edge the register file captures the data. This makes busy drop exactly when the value becomes readable.
  - Simultaneous set and clear of the same register: set wins.
  - flush=1 clears all sb bits; a set in the same cycle is ignored. The output stage is unaffected by flush.
- issue_ready = ~sb[issue_rd] (rd=0 always ready). This blocks WAW while a prior write to the same register is outstanding.
- rs1_busy = sb[rs1_sel], rs2_busy = sb[rs2_sel]; both read as 0 for register 0. These are combinational from registered state; there is no bypass.
- Requesters must hold req_valid, req_rd and req_data stable until accepted. A requester that drops valid before being granted loses nothing; the pointer is unaffected.

Decomposition:
- Shared package wb_pkg:
  - Constants: XLEN, REG_AW, NUM_REGS.
  - Typedef: wb_req_t {rd, data}.
  - Function: rr_pick(valid, ptr) returning grant index and found flag.
- One natural sub-module: wb_rr_arbiter (NUM_REQ-wide round-robin grant plus pointer register).
- The scoreboard and output stage live in the top module.

Test Plan:
- Reset then idle: reset_n=0 mid-stream, release -> reg_write=0, rd_sel=0, wb_data=0, rs1_busy=0 for rs1_sel=1..31, issue_ready=1.
- Single write: req_valid=3'b001, rd=5, data=32'hDEADBEEF -> req_ready=3'b001 in cycle 0; cycle 1 shows reg_write=1, rd_sel=5, wb_data=DEADBEEF; cycle 2 shows reg_write=0.
- Fairness: all three valid continuously with distinct rd -> grants rotate 0,1,2,0,1,2 and reg_write stays high every cycle.
- Hazard: issue rd=7, then rs1_sel=7 -> rs1_busy=1 and issue_ready=0 for issue_rd=7; requester 1 writes rd=7 -> busy drops on the edge reg_write=1 is sampled, and issue_ready returns to 1.
- rd=0 corner: request rd=0 data=32'h1 -> accepted, reg_write stays 0; issue_rd=0 never sets busy; rs1_sel=0 gives rs1_busy=0.
- Simultaneous events: in one cycle, commit reg 9 while issuing rd=9 -> sb[9] remains 1; then assert flush together with issue rd=4 -> all busy bits 0, including 4.
